alu_nzcv_pipe: RTL

Registered, handshaked ALU with an architectural NZCV flags register, parametrised datapath width. It supersedes the purely combinational 2-bit-op ALU+flags block. It adds carry-in ops (ADC/SBC), EOR, optional flag update per op, an explicit flags load port and valid/ready flow control. It sits between the execute-stage operand mux and writeback in the core datapath.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_nzcv_pipe_if.sv | 31 +++
 rtl/alu_nzcv_core.sv | 54 +++++
 rtl/alu_nzcv_pipe.sv | 62 ++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the NZCV ALU pipe: op encoding and flag bit positions.
// Pure declarations, no logic.
// Imported by the interface, the core and the pipe.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_ORR  = 3'b011,
        ALU_ADC  = 3'b100,
        ALU_SBC  = 3'b101,
        ALU_EOR  = 3'b110,
        ALU_RSVD = 3'b111
    } alu_op_t;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    // Sub-type ops feed ~b into the adder.
    function automatic logic is_sub_op(input alu_op_t op);
        return (op == ALU_SUB) || (op == ALU_SBC);
    endfunction

endpackage

// File: rtl/alu_nzcv_pipe_if.sv
// Request/response bundle between the operand mux, the ALU pipe and writeback.
// Signal names keep the i_/o_ sense as seen from the ALU.
// The ALU takes the slave modport; the driver of operands takes master.
interface alu_nzcv_pipe_if #(parameter int N = 64);
    import alu_pkg::*;

    logic          i_valid;
    logic          o_ready;
    logic [N-1:0]  i_a;
    logic [N-1:0]  i_b;
    alu_op_t       i_op;
    logic          i_set_flags;
    logic          i_nzcv_we;
    logic [3:0]    i_nzcv_wdata;
    logic          o_valid;
    logic          i_ready;
    logic [N-1:0]  o_result;
    logic [3:0]    o_nzcv;
    logic [3:0]    o_flags;

    modport master (
        output i_valid, i_a, i_b, i_op, i_set_flags, i_nzcv_we, i_nzcv_wdata, i_ready,
        input  o_ready, o_valid, o_result, o_nzcv, o_flags
    );

    modport slave (
        input  i_valid, i_a, i_b, i_op, i_set_flags, i_nzcv_we, i_nzcv_wdata, i_ready,
        output o_ready, o_valid, o_result, o_nzcv, o_flags
    );

endinterface

// File: rtl/alu_nzcv_core.sv
// Combinational ALU: result and NZCV from a, b, op and carry-in.
// Latency: zero (pure combinational).
// Backpressure: none; the enclosing pipe decides when the result is captured.
module alu_nzcv_core
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  alu_op_t      op,
    input  logic         cin,
    output logic [N-1:0] result,
    output logic [3:0]   nzcv
);

    logic [N-1:0] b_eff;
    logic         c_add;
    logic [N:0]   sum;
    logic         arith;

    // Shared N+1 bit adder; sub-type ops add ~b, carry-in selected per op.
    always_comb begin
        b_eff = is_sub_op(op) ? ~b : b;
        unique case (op)
            ALU_SUB:          c_add = 1'b1;
            ALU_ADC, ALU_SBC: c_add = cin;
            default:          c_add = 1'b0;
        endcase
        sum = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, c_add};
    end

    // Result select and flag generation; logic ops and reserved clear C and V.
    always_comb begin
        arith  = 1'b0;
        result = '0;
        unique case (op)
            ALU_ADD, ALU_SUB, ALU_ADC, ALU_SBC: begin
                result = sum[N-1:0];
                arith  = 1'b1;
            end
            ALU_AND:  result = a & b;
            ALU_ORR:  result = a | b;
            ALU_EOR:  result = a ^ b;
            default:  result = '0;
        endcase
        nzcv         = 4'b0000;
        nzcv[NZCV_N] = result[N-1];
        nzcv[NZCV_Z] = (result == '0);
        nzcv[NZCV_C] = arith & sum[N];
        nzcv[NZCV_V] = arith & (a[N-1] == b_eff[N-1]) & (result[N-1] != a[N-1]);
    end

endmodule

// File: rtl/alu_nzcv_pipe.sv
// Registered ALU with handshake and architectural NZCV flags register.
// Latency: 1 cycle from accept to o_valid; 1 op/cycle while i_ready is high.
// Backpressure: single output stage, o_ready = !o_valid | i_ready, outputs held while stalled.
module alu_nzcv_pipe
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    alu_nzcv_pipe_if.slave bus
);

    logic [N-1:0] core_result;
    logic [3:0]   core_nzcv;
    logic [3:0]   flags;
    logic         out_valid;
    logic         accept;

    // Carry-in is the architectural C at the accept cycle, so chained ADC/SBC
    // see the previous accepted op's flags without a bubble.
    alu_nzcv_core #(.N(N)) u_core (
        .a      (bus.i_a),
        .b      (bus.i_b),
        .op     (bus.i_op),
        .cin    (flags[NZCV_C]),
        .result (core_result),
        .nzcv   (core_nzcv)
    );

    assign bus.o_ready = !out_valid || bus.i_ready;
    assign accept      = bus.i_valid && bus.o_ready;
    assign bus.o_valid = out_valid;
    assign bus.o_flags = flags;

    // Output stage: load on accept, clear when drained with nothing new, else hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_valid    <= 1'b0;
            bus.o_result <= '0;
            bus.o_nzcv   <= 4'b0000;
        end else if (accept) begin
            out_valid    <= 1'b1;
            bus.o_result <= core_result;
            bus.o_nzcv   <= core_nzcv;
        end else if (out_valid && bus.i_ready) begin
            out_valid    <= 1'b0;
        end
    end

    // Flags register: direct load wins over a flag-setting op in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            flags <= 4'b0000;
        end else if (bus.i_nzcv_we) begin
            flags <= bus.i_nzcv_wdata;
        end else if (accept && bus.i_set_flags) begin
            flags <= core_nzcv;
        end
    end

endmodule
